bus_generator_arbiter: RTL and testbench

//  Shared-bus model with a round-robin arbiter between DRVRS ports. Each port has an input FIFO (pndng/D_pop/pop) and an output FIFO (push/D_push).

---
 rtl/bus_generator_arbiter_pkg.sv | 22 ++
 rtl/bus_generator_arbiter_if.sv | 28 ++
 rtl/bus_generator_arbiter_rr_arbiter.sv | 33 +++
 rtl/bus_generator_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_generator_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_generator_arbiter_pkg.sv
// Shared definitions for the bus generator arbiter: ID width, FSM states and
// the destination-field extractor.
package bus_arb_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // Destination ID sits in the top ID_W bits of a pckg_sz-bit packet.
    function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned pckg_sz);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (pckg_sz - ID_W);
        return sh[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_generator_arbiter_if.sv
// Bundle of the per-port FIFO handshake signals between the arbiter and the
// driver/monitor FIFOs.
interface bus_generator_arbiter_if #(
    parameter int DRVRS   = 8,
    parameter int PCKG_SZ = 16
);
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [DRVRS*PCKG_SZ-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_generator_arbiter_rr_arbiter.sv
// Combinational round-robin search: grants the requester closest after i_ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter  int N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx
);

    int w_best_dist;
    int w_dist;

    // Distance 0 is the port right after i_ptr; the owner of i_ptr is N-1.
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_idx   = '0;
        w_best_dist = N;
        w_dist      = 0;
        for (int j = 0; j < N; j++) begin
            if (i_req[j]) begin
                w_dist = (j + N - 1 - int'(i_ptr)) % N;
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    o_gnt_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus model: round-robin grant, pop one packet, push it to its destination
// or broadcast it. Optional macro BCAST_SELF_EN lets broadcast/self-unicast reach the source.
module bus_generator_arbiter
    import bus_arb_pkg::*;
#(
    parameter int              DRVRS     = 8,
    parameter int              PCKG_SZ   = 16,
    parameter logic [ID_W-1:0] BROADCAST = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_generator_arbiter_if.master bus
);

    localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    state_t             r_state;
    state_t             w_state_nx;
    logic [IDX_W-1:0]   r_src;
    logic [IDX_W-1:0]   w_src_nx;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nx;
    logic [PCKG_SZ-1:0] r_data;
    logic [PCKG_SZ-1:0] w_data_nx;
    logic [DRVRS-1:0]   r_pop;
    logic [DRVRS-1:0]   w_pop_nx;
    logic [DRVRS-1:0]   r_push;
    logic [DRVRS-1:0]   w_push_nx;

    logic               w_gnt_valid;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [PCKG_SZ-1:0] w_words [DRVRS];
    logic [PCKG_SZ-1:0] w_pop_word;
    logic [ID_W-1:0]    w_dest;
    logic [DRVRS-1:0]   w_push_mask;

    for (genvar g = 0; g < DRVRS; g++) begin : g_words
        assign w_words[g] = bus.D_pop[g*PCKG_SZ +: PCKG_SZ];
    end

    assign w_pop_word = w_words[r_src];
    assign w_dest     = get_dest(PKT_MAX_W'(w_pop_word), PCKG_SZ);

    rr_arbiter #(.N(DRVRS)) u_rr_arbiter (
        .i_req       (bus.pndng),
        .i_ptr       (r_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Decoded from the word being popped so push can be registered for the PUSH cycle.
    always_comb begin
        w_push_mask = '0;
        for (int i = 0; i < DRVRS; i++) begin
`ifdef BCAST_SELF_EN
            if (w_dest == BROADCAST || 32'(w_dest) == i) begin
                w_push_mask[i] = 1'b1;
            end
`else
            if (32'(r_src) != i) begin
                if (w_dest == BROADCAST || 32'(w_dest) == i) begin
                    w_push_mask[i] = 1'b1;
                end
            end
`endif
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_ptr_nx   = r_ptr;
        w_data_nx  = r_data;
        w_pop_nx   = '0;
        w_push_nx  = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_src_nx             = w_gnt_idx;
                    w_pop_nx[w_gnt_idx]  = 1'b1;
                    w_state_nx           = POP;
                end
            end
            POP: begin
                w_data_nx  = w_pop_word;
                w_push_nx  = w_push_mask;
                w_ptr_nx   = r_src;
                w_state_nx = PUSH;
            end
            PUSH: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_ptr   <= IDX_W'(DRVRS - 1);
            r_data  <= '0;
            r_pop   <= '0;
            r_push  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_src   <= w_src_nx;
            r_ptr   <= w_ptr_nx;
            r_data  <= w_data_nx;
            r_pop   <= w_pop_nx;
            r_push  <= w_push_nx;
        end
    end

    assign bus.pop    = r_pop;
    assign bus.push   = r_push;
    assign bus.D_push = {DRVRS{r_data}};

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Scoreboard bench for bus_generator_arbiter: directed scenarios followed by random
// traffic, predicted by a transaction-level model of the shared bus.
module tb_bus_generator_arbiter;

    localparam int D = 8;
    localparam int P = 16;

    typedef struct {
        int          cyc;
        logic [15:0] mask;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_generator_arbiter_if #(.DRVRS(D), .PCKG_SZ(P)) bus ();

    bus_generator_arbiter #(.DRVRS(D), .PCKG_SZ(P), .BROADCAST(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [P-1:0] fifo_q [D][$];
    exp_t         exp_pop[$];
    exp_t         exp_push[$];
    logic [15:0]  obs_pop[$];
    logic [15:0]  obs_push[$];
    logic [15:0]  obs_data[$];

    int       cyc    = 0;
    int       n_chk  = 0;
    int       n_err  = 0;
    bit       mon_en = 1'b0;
    int       m_ptr  = D - 1;
    int       m_free = 0;
    int       m_src  = 0;
    int       m_cap  = 0;
    bit       m_infl = 1'b0;
    logic [P-1:0] m_last = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] at(input logic [15:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 16'hxxxx;
    endfunction

    // Delivery rule: broadcast to every other port, unicast to a valid other port.
    function automatic logic [15:0] exp_mask(input int src, input logic [P-1:0] pkt);
        logic [15:0] m;
        int          dest;
        m    = '0;
        dest = int'(pkt[P-1 -: 8]);
        if (dest == 255) begin
            for (int i = 0; i < D; i++) m[i] = 1'b1;
`ifndef BCAST_SELF_EN
            m[src] = 1'b0;
`endif
        end else if (dest < D) begin
`ifdef BCAST_SELF_EN
            m[dest] = 1'b1;
`else
            if (dest != src) m[dest] = 1'b1;
`endif
        end
        return m;
    endfunction

    task automatic drive_inputs();
        logic [D-1:0][P-1:0] dv;
        logic [D-1:0]        pv;
        for (int i = 0; i < D; i++) begin
            pv[i] = (fifo_q[i].size() != 0);
            dv[i] = pv[i] ? fifo_q[i][0] : '0;
        end
        bus.pndng = pv;
        bus.D_pop = dv;
    endtask

    // Model of what the bus does at clock edge number cyc.
    task automatic model_edge(input bit r);
        logic [P-1:0] pkt;
        logic [15:0]  m;
        exp_t         e;
        if (m_infl && cyc == m_cap) begin
            pkt    = fifo_q[m_src].pop_front();
            m_infl = 1'b0;
            if (!r) begin
                m = exp_mask(m_src, pkt);
                if (m != 0) begin
                    e.cyc = cyc; e.mask = m; e.data = pkt;
                    exp_push.push_back(e);
                end
                m_last = pkt;
                m_ptr  = m_src;
                m_free = cyc + 2;
            end
        end
        if (r) begin
            m_ptr  = D - 1;
            m_last = '0;
            m_free = cyc + 1;
            m_infl = 1'b0;
        end else if (!m_infl && cyc >= m_free) begin
            for (int k = 1; k <= D; k++) begin
                int s;
                s = (m_ptr + k) % D;
                if (!m_infl && fifo_q[s].size() != 0) begin
                    m_infl = 1'b1;
                    m_src  = s;
                    m_cap  = cyc + 1;
                    e.cyc = cyc; e.mask = 16'(1 << s); e.data = '0;
                    exp_pop.push_back(e);
                end
            end
        end
    endtask

    task automatic tick(input bit r);
        reset = r;
        drive_inputs();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        model_edge(r);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic clear_obs();
        obs_pop.delete();
        obs_push.delete();
        obs_data.delete();
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < D; i++) if (fifo_q[i].size() != 0) return 1'b0;
        return !m_infl && exp_pop.size() == 0 && exp_push.size() == 0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t ex;
            if (bus.pop != 0) begin
                obs_pop.push_back(16'(bus.pop));
                if (exp_pop.size() == 0) begin
                    chk("pop_unexpected", bus.pop, 0);
                end else begin
                    ex = exp_pop.pop_front();
                    chk("pop_cycle", cyc, ex.cyc);
                    chk("pop_mask", bus.pop, ex.mask);
                end
            end else if (exp_pop.size() != 0 && exp_pop[0].cyc <= cyc) begin
                ex = exp_pop.pop_front();
                chk("pop_missing", bus.pop, ex.mask);
            end
            if (bus.push != 0) begin
                obs_push.push_back(16'(bus.push));
                obs_data.push_back(bus.D_push[P-1:0]);
                if (exp_push.size() == 0) begin
                    chk("push_unexpected", bus.push, 0);
                end else begin
                    ex = exp_push.pop_front();
                    chk("push_cycle", cyc, ex.cyc);
                    chk("push_mask", bus.push, ex.mask);
                    chk("push_data", bus.D_push[P-1:0], ex.data);
                end
            end else if (exp_push.size() != 0 && exp_push[0].cyc <= cyc) begin
                ex = exp_push.pop_front();
                chk("push_missing", bus.push, ex.mask);
            end
            chk("d_push_all", bus.D_push, {D{m_last}});
        end
    end

    initial begin
        int  bound;
        bit  done;
        bus.pndng = '0;
        bus.D_pop = '0;

        tick(1'b1);
        mon_en = 1'b1;
        tick(1'b1);
        @(negedge clk);
        chk("reset_pop", bus.pop, 0);
        chk("reset_push", bus.push, 0);
        chk("reset_dpush", bus.D_push, 0);

        // Unicast from port 1 to port 2
        clear_obs();
        fifo_q[1].push_back(16'h0208);
        run(6);
        chk("uni_pop", at(obs_pop, 0), 16'h0002);
        chk("uni_push", at(obs_push, 0), 16'h0004);
        chk("uni_data", at(obs_data, 0), 16'h0208);

        // Broadcast from port 3
        clear_obs();
        fifo_q[3].push_back(16'hFF55);
        run(6);
        chk("bc_pop", at(obs_pop, 0), 16'h0008);
`ifdef BCAST_SELF_EN
        chk("bc_push", at(obs_push, 0), 16'h00FF);
`else
        chk("bc_push", at(obs_push, 0), 16'h00F7);
`endif
        chk("bc_data", at(obs_data, 0), 16'hFF55);

        // Round robin among 0,2,5 from a fresh pointer
        tick(1'b1);
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            fifo_q[0].push_back(16'h0100 | 16'(k));
            fifo_q[2].push_back(16'h0110 | 16'(k));
            fifo_q[5].push_back(16'h0150 | 16'(k));
        end
        run(45);
        chk("rr_0", at(obs_pop, 0), 16'h0001);
        chk("rr_1", at(obs_pop, 1), 16'h0004);
        chk("rr_2", at(obs_pop, 2), 16'h0020);
        chk("rr_3", at(obs_pop, 3), 16'h0001);
        chk("rr_count", obs_pop.size(), 12);

        // Invalid destination is popped and dropped
        clear_obs();
        fifo_q[0].push_back(16'h0911);
        fifo_q[0].push_back(16'h0322);
        run(10);
        chk("inv_pops", obs_pop.size(), 2);
        chk("inv_pushes", obs_push.size(), 1);
        chk("inv_next_push", at(obs_push, 0), 16'h0008);
        chk("inv_next_data", at(obs_data, 0), 16'h0322);

        // Reset during POP discards the packet and restarts the search at port 0
        fifo_q[1].push_back(16'h0033);
        run(6);
        clear_obs();
        fifo_q[6].push_back(16'h0044);
        done  = 1'b0;
        bound = 0;
        while (!done && bound < 10) begin
            if (m_infl && m_cap == cyc + 1) done = 1'b1;
            else begin tick(1'b0); bound++; end
        end
        chk("rst_reach_pop", done, 1'b1);
        tick(1'b1);
        fifo_q[0].push_back(16'h0155);
        fifo_q[2].push_back(16'h0166);
        run(10);
        chk("rst_pop_src6", at(obs_pop, 0), 16'h0040);
        chk("rst_first_grant", at(obs_pop, 1), 16'h0001);
        chk("rst_pushes", obs_push.size(), 2);
        chk("rst_push0", at(obs_push, 0), 16'h0002);

        // Self-unicast from port 4
        clear_obs();
        fifo_q[4].push_back(16'h0401);
        run(6);
        chk("self_pop", at(obs_pop, 0), 16'h0010);
`ifdef BCAST_SELF_EN
        chk("self_push", at(obs_push, 0), 16'h0010);
`else
        chk("self_push_none", obs_push.size(), 0);
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(2) == 0) begin
                int          p;
                int          r;
                logic [7:0]  dst;
                p = $urandom_range(D - 1);
                r = $urandom_range(9);
                if (r <= 6)      dst = 8'($urandom_range(D - 1));
                else if (r == 7) dst = 8'hFF;
                else if (r == 8) dst = 8'($urandom_range(254, D));
                else             dst = 8'(p);
                if (fifo_q[p].size() < 4)
                    fifo_q[p].push_back({dst, 8'($urandom_range(255))});
            end
            tick($urandom_range(199) == 0);
        end

        bound = 0;
        while (!all_idle() && bound < 300) begin
            tick(1'b0);
            bound++;
        end
        chk("drain_done", all_idle(), 1'b1);
        run(4);
        chk("exp_pop_left", exp_pop.size(), 0);
        chk("exp_push_left", exp_push.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
